// File: rtl/simon_pkg.sv
// Shared definitions for the Simon sequence controller: the controller state
// encoding and the mode LED pattern shown for each state.
package simon_pkg;

  typedef enum logic [2:0] {
    StInput,
    StPlayback,
    StRepeat,
    StDone,
    StWin
  } state_e;

  localparam logic [2:0] LedInput    = 3'b001;
  localparam logic [2:0] LedPlayback = 3'b010;
  localparam logic [2:0] LedRepeat   = 3'b100;
  localparam logic [2:0] LedDone     = 3'b111;
  localparam logic [2:0] LedWin      = 3'b011;

endpackage

// File: rtl/simon_step_timer.sv
// Up-counter with synchronous clear and a terminal-count flag.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr_i     - return the count to zero (wins over en_i)
//   en_i      - advance the count by one
//   tc_o      - count is at TERM-1
module simon_step_timer #(
  parameter int unsigned TERM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = (TERM > 1) ? $clog2(TERM) : 1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == CW'(TERM - 1));

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon-style pattern sequence controller. The player adds one pattern per
// round; the stored sequence is played back, then must be repeated. A wrong
// entry (or, optionally, a stalled repeat) ends the game; completing DEPTH
// rounds wins it.
//
// Optional feature: define SIMON_TIMEOUT_EN to end the game when no entry
// arrives for TIMEOUT cycles during the repeat phase. Without it the repeat
// phase waits indefinitely.
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   pat_valid/pat_in      - one-cycle entry strobe and entered pattern
//   pat_legal             - datapath legality of pat_in (used in INPUT only)
//   mem_addr/mem_wen/
//   mem_wdata/rd_data     - external pattern memory, combinational read
//   disp_pattern          - pattern shown to the player
//   level                 - number of stored entries
//   mode_leds, fail, win  - game status, decoded from state
module simon_seq_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned PAT_W      = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PLAY_TICKS = 4,
  parameter int unsigned TIMEOUT    = 64,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pat_valid,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             pat_legal,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_wen,
  output logic [PAT_W-1:0] mem_wdata,
  input  logic [PAT_W-1:0] rd_data,
  output logic [PAT_W-1:0] disp_pattern,
  output logic [AW:0]      level,
  output logic [2:0]       mode_leds,
  output logic             fail,
  output logic             win
);

  state_e        state_q;
  logic [AW:0]   level_q;
  logic [AW-1:0] play_idx_q;
  logic [AW-1:0] rep_idx_q;

  logic accept;
  logic last_play;
  logic last_rep;
  logic level_full;
  logic tick_tc;
  logic timeout;

  assign accept     = pat_valid && pat_legal;
  assign last_play  = ({1'b0, play_idx_q} == (level_q - 1'b1));
  assign last_rep   = ({1'b0, rep_idx_q} == (level_q - 1'b1));
  assign level_full = (level_q == (AW+1)'(DEPTH));

  // Playback tick: restarts at every index advance and whenever not playing,
  // so each entry into PLAYBACK starts from tick 0.
  simon_step_timer #(
    .TERM (PLAY_TICKS)
  ) u_tick_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i ((state_q != StPlayback) || tick_tc),
    .en_i  (state_q == StPlayback),
    .tc_o  (tick_tc)
  );

`ifdef SIMON_TIMEOUT_EN
  logic rep_tc;

  // Idle timer: any entry restarts the count.
  simon_step_timer #(
    .TERM (TIMEOUT)
  ) u_rep_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i ((state_q != StRepeat) || pat_valid),
    .en_i  (state_q == StRepeat),
    .tc_o  (rep_tc)
  );

  assign timeout = rep_tc;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StInput;
      level_q    <= '0;
      play_idx_q <= '0;
      rep_idx_q  <= '0;
    end else begin
      unique case (state_q)
        StInput: begin
          if (accept) begin
            level_q    <= level_q + 1'b1;
            play_idx_q <= '0;
            state_q    <= StPlayback;
          end
        end
        StPlayback: begin
          if (tick_tc) begin
            if (last_play) begin
              rep_idx_q <= '0;
              state_q   <= StRepeat;
            end else begin
              play_idx_q <= play_idx_q + 1'b1;
            end
          end
        end
        StRepeat: begin
          // An entry in the same cycle as the timeout takes priority.
          if (pat_valid) begin
            if (pat_in != rd_data) begin
              state_q <= StDone;
            end else if (last_rep) begin
              state_q <= level_full ? StWin : StInput;
            end else begin
              rep_idx_q <= rep_idx_q + 1'b1;
            end
          end else if (timeout) begin
            state_q <= StDone;
          end
        end
        StDone, StWin: begin
          // Terminal until reset.
        end
        default: state_q <= StInput;
      endcase
    end
  end

  always_comb begin
    mem_addr     = level_q[AW-1:0];
    mem_wen      = 1'b0;
    mem_wdata    = pat_in;
    disp_pattern = '0;
    mode_leds    = LedInput;
    fail         = 1'b0;
    win          = 1'b0;
    unique case (state_q)
      StInput: begin
        mem_wen      = accept;
        disp_pattern = pat_in;
        mode_leds    = LedInput;
      end
      StPlayback: begin
        mem_addr     = play_idx_q;
        disp_pattern = rd_data;
        mode_leds    = LedPlayback;
      end
      StRepeat: begin
        mem_addr     = rep_idx_q;
        disp_pattern = pat_in;
        mode_leds    = LedRepeat;
      end
      StDone: begin
        mode_leds = LedDone;
        fail      = 1'b1;
      end
      StWin: begin
        mode_leds = LedWin;
        win       = 1'b1;
      end
      default: mode_leds = LedInput;
    endcase
  end

  assign level = level_q;

endmodule

// File: tb/tb_simon_seq_ctrl.sv
module tb_simon_seq_ctrl;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             pat_valid;
  logic [PAT_W-1:0] pat_in;
  logic             pat_legal;
  logic [AW-1:0]    mem_addr;
  logic             mem_wen;
  logic [PAT_W-1:0] mem_wdata;
  logic [PAT_W-1:0] rd_data;
  logic [PAT_W-1:0] disp_pattern;
  logic [AW:0]      level;
  logic [2:0]       mode_leds;
  logic             fail;
  logic             win;

  int n_checks = 0;
  int n_errors = 0;

  logic [PAT_W-1:0] mem [DEPTH];
  logic [PAT_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  // External pattern memory.
  always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_wdata;
  assign rd_data = mem[mem_addr];

  simon_seq_ctrl #(
    .PAT_W      (4),
    .DEPTH      (4),
    .PLAY_TICKS (2),
    .TIMEOUT    (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pat_valid    (pat_valid),
    .pat_in       (pat_in),
    .pat_legal    (pat_legal),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wdata    (mem_wdata),
    .rd_data      (rd_data),
    .disp_pattern (disp_pattern),
    .level        (level),
    .mode_leds    (mode_leds),
    .fail         (fail),
    .win          (win)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    pat_valid = 1'b0;
    pat_legal = 1'b0;
    pat_in    = '0;
    exp_q.delete();
    step();
    rst = 1'b0;
  endtask

  // Enter a new pattern in INPUT and follow the whole playback.
  task automatic add_round(input logic [PAT_W-1:0] p);
    pat_valid = 1'b1; pat_in = p; pat_legal = 1'b1;
    #1;
    n_checks++;
    if (mem_wen !== 1'b1 || mem_addr !== AW'(exp_q.size()) || mem_wdata !== p) begin
      n_errors++;
      $display("FAIL add_write: wen=%b addr=%0d data=%b want wen=1 addr=%0d data=%b",
               mem_wen, mem_addr, mem_wdata, exp_q.size(), p);
    end
    step();
    pat_valid = 1'b0;
    exp_q.push_back(p);
    foreach (exp_q[i]) begin
      for (int t = 0; t < 2; t++) begin
        n_checks++;
        if (mode_leds !== 3'b010 || disp_pattern !== exp_q[i]) begin
          n_errors++;
          $display("FAIL playback idx%0d t%0d: leds=%b disp=%b want leds=010 disp=%b",
                   i, t, mode_leds, disp_pattern, exp_q[i]);
        end
        step();
      end
    end
    n_checks++;
    if (mode_leds !== 3'b100) begin
      n_errors++;
      $display("FAIL enter_repeat: leds=%b want 100", mode_leds);
    end
  endtask

  task automatic repeat_all();
    foreach (exp_q[i]) begin
      pat_valid = 1'b1; pat_in = exp_q[i]; pat_legal = 1'b0;
      #1;
      n_checks++;
      if (disp_pattern !== exp_q[i] || mem_wen !== 1'b0) begin
        n_errors++;
        $display("FAIL repeat_disp idx%0d: disp=%b wen=%b want disp=%b wen=0",
                 i, disp_pattern, mem_wen, exp_q[i]);
      end
      step();
    end
    pat_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pat_valid = 1'b0; pat_legal = 1'b0; pat_in = '0;
    #1;  // before the first rising edge
    n_checks++;
    if (mode_leds !== 3'b001 || level !== 3'd0 || fail !== 1'b0 || win !== 1'b0
        || mem_wen !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: leds=%b level=%0d fail=%b win=%b wen=%b want 001 0 0 0 0",
               mode_leds, level, fail, win, mem_wen);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_illegal_entry();
    pat_valid = 1'b1; pat_in = 4'b0011; pat_legal = 1'b0;
    #1;
    n_checks++;
    if (mem_wen !== 1'b0 || disp_pattern !== 4'b0011) begin
      n_errors++;
      $display("FAIL illegal_wen: wen=%b disp=%b want 0 0011", mem_wen, disp_pattern);
    end
    step();
    pat_valid = 1'b0;
    n_checks++;
    if (mode_leds !== 3'b001 || level !== 3'd0) begin
      n_errors++;
      $display("FAIL illegal_state: leds=%b level=%0d want 001 0", mode_leds, level);
    end
  endtask

  task automatic test_win();
    logic [PAT_W-1:0] pats [4] = '{4'b0001, 4'b0100, 4'b1000, 4'b0010};
    reset_dut();
    for (int r = 0; r < 4; r++) begin
      add_round(pats[r]);
      repeat_all();
      if (r < 3) begin
        n_checks++;
        if (mode_leds !== 3'b001 || level !== 3'(r + 1) || win !== 1'b0) begin
          n_errors++;
          $display("FAIL round%0d_end: leds=%b level=%0d win=%b want 001 %0d 0",
                   r, mode_leds, level, win, r + 1);
        end
      end
    end
    pat_valid = 1'b1; pat_in = 4'b1111; pat_legal = 1'b1;
    step();
    step();
    n_checks++;
    if (mode_leds !== 3'b011 || win !== 1'b1 || fail !== 1'b0 || disp_pattern !== 4'b0000
        || mem_wen !== 1'b0 || level !== 3'd4) begin
      n_errors++;
      $display("FAIL win: leds=%b win=%b fail=%b disp=%b wen=%b level=%0d want 011 1 0 0000 0 4",
               mode_leds, win, fail, disp_pattern, mem_wen, level);
    end
    pat_valid = 1'b0;
  endtask

  task automatic test_fail();
    reset_dut();
    add_round(4'b0001);
    repeat_all();
    add_round(4'b0100);
    pat_valid = 1'b1; pat_in = 4'b0001;
    step();
    n_checks++;
    if (mode_leds !== 3'b100) begin
      n_errors++;
      $display("FAIL first_match: leds=%b want 100", mode_leds);
    end
    pat_in = 4'b1000;
    step();
    pat_in = 4'b0001; pat_legal = 1'b1;  // keep strobing: must be ignored
    n_checks++;
    if (mode_leds !== 3'b111 || fail !== 1'b1 || win !== 1'b0 || disp_pattern !== 4'b0000) begin
      n_errors++;
      $display("FAIL done: leds=%b fail=%b win=%b disp=%b want 111 1 0 0000",
               mode_leds, fail, win, disp_pattern);
    end
    step(); step(); step();
    #1;
    n_checks++;
    if (mode_leds !== 3'b111 || fail !== 1'b1 || mem_wen !== 1'b0 || level !== 3'd2) begin
      n_errors++;
      $display("FAIL done_sticky: leds=%b fail=%b wen=%b level=%0d want 111 1 0 2",
               mode_leds, fail, mem_wen, level);
    end
    pat_valid = 1'b0;
  endtask

  task automatic test_timeout();
    reset_dut();
    add_round(4'b0001);
    repeat_all();
    add_round(4'b0100);
    repeat (6) step();
    pat_valid = 1'b1; pat_in = 4'b0001;  // restarts the idle count
    step();
    pat_valid = 1'b0;
    repeat (6) step();
    n_checks++;
    if (mode_leds !== 3'b100) begin
      n_errors++;
      $display("FAIL timer_clear: leds=%b want 100", mode_leds);
    end
    pat_valid = 1'b1; pat_in = 4'b0100;
    step();
    pat_valid = 1'b0;
    n_checks++;
    if (mode_leds !== 3'b001 || level !== 3'd2) begin
      n_errors++;
      $display("FAIL slow_round: leds=%b level=%0d want 001 2", mode_leds, level);
    end
    add_round(4'b1000);
`ifdef SIMON_TIMEOUT_EN
    repeat (7) step();
    n_checks++;
    if (mode_leds !== 3'b100) begin
      n_errors++;
      $display("FAIL pre_timeout: leds=%b want 100", mode_leds);
    end
    step();
    n_checks++;
    if (mode_leds !== 3'b111 || fail !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout: leds=%b fail=%b want 111 1", mode_leds, fail);
    end
`else
    repeat (100) step();
    n_checks++;
    if (mode_leds !== 3'b100 || fail !== 1'b0) begin
      n_errors++;
      $display("FAIL no_timeout: leds=%b fail=%b want 100 0", mode_leds, fail);
    end
`endif
  endtask

  task automatic test_reset_mid_playback();
    reset_dut();
    pat_valid = 1'b1; pat_in = 4'b0110; pat_legal = 1'b1;
    step();
    pat_valid = 1'b0;
    n_checks++;
    if (mode_leds !== 3'b010 || level !== 3'd1) begin
      n_errors++;
      $display("FAIL pre_reset_play: leds=%b level=%0d want 010 1", mode_leds, level);
    end
    step();
    rst = 1'b1;
    #1;  // no clock edge in between
    n_checks++;
    if (mode_leds !== 3'b001 || level !== 3'd0 || fail !== 1'b0 || win !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: leds=%b level=%0d fail=%b win=%b want 001 0 0 0",
               mode_leds, level, fail, win);
    end
    step();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_illegal_entry();
    test_win();
    test_fail();
    test_timeout();
    test_reset_mid_playback();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
